// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the L1 data cache.
// Optional feature macro: DCACHE_PERF_COUNTERS_EN (see l1_dcache.sv).
package dcache_types;

   localparam int LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } dcache_state_t;

   // Merge the enabled byte lanes of new_w into old_w.
   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Direct-mapped line storage: valid/dirty/tag/data per set.
// Valid and dirty reset asynchronously; tag and data are never reset.
// One combinational read port, one full-entry write port.
module dcache_array
   import dcache_types::*;
#(
   parameter int S_INDEX = 4,
   parameter int S_TAG   = 23
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [S_INDEX-1:0]  rd_idx_i,
   output logic                rd_valid_o,
   output logic                rd_dirty_o,
   output logic [S_TAG-1:0]    rd_tag_o,
   output logic [LINE_W-1:0]   rd_data_o,
   input  logic                we_i,
   input  logic [S_INDEX-1:0]  wr_idx_i,
   input  logic                wr_valid_i,
   input  logic                wr_dirty_i,
   input  logic [S_TAG-1:0]    wr_tag_i,
   input  logic [LINE_W-1:0]   wr_data_i
);
   localparam int SETS = 2**S_INDEX;

   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [S_TAG-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];

   // Status bits: cleared on reset so every line starts invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
         dirty_q[wr_idx_i] <= wr_dirty_i;
      end
   end

   // Tag and data payload: no reset, contents only matter once valid.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// FSM: IDLE -> COMPARE -> (hit: respond) | WRITEBACK -> ALLOCATE -> COMPARE.
// Define DCACHE_PERF_COUNTERS_EN to add saturating hit/miss counters.
module l1_dcache
   import dcache_types::*;
#(
   parameter  int S_INDEX  = 4,
   parameter  int S_OFFSET = 5,
   localparam int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [3:0]          mem_byte_enable,
   input  logic [31:0]         mem_address,
   input  logic [31:0]         mem_wdata,
   output logic                mem_resp,
   output logic [31:0]         mem_rdata,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [31:0]         pmem_address,
   output logic [LINE_W-1:0]   pmem_wdata,
   input  logic [LINE_W-1:0]   pmem_rdata,
   input  logic                pmem_resp
`ifdef DCACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0]         perf_hits,
   output logic [31:0]         perf_misses
`endif
);
   dcache_state_t state_q, state_d;

   // Missing request's tag/index, held so pmem outputs stay stable
   // even if the requester drops the request mid-transaction.
   logic [S_TAG-1:0]   req_tag_q, req_tag_d;
   logic [S_INDEX-1:0] req_idx_q, req_idx_d;

   logic [S_TAG-1:0]   addr_tag;
   logic [S_INDEX-1:0] addr_idx;
   logic [2:0]         addr_word;
   logic               unused_addr_lsb;
   logic               req, hit;
   logic [31:0]        cur_word;

   logic [S_INDEX-1:0] rd_idx;
   logic               rd_valid, rd_dirty;
   logic [S_TAG-1:0]   rd_tag;
   logic [LINE_W-1:0]  rd_data;

   logic               we, wr_valid, wr_dirty;
   logic [S_TAG-1:0]   wr_tag;
   logic [LINE_W-1:0]  wr_data;

   assign addr_tag        = mem_address[31 -: S_TAG];
   assign addr_idx        = mem_address[S_OFFSET +: S_INDEX];
   assign addr_word       = mem_address[4:2];
   assign unused_addr_lsb = ^mem_address[1:0];
   assign req             = mem_read | mem_write;

   // In COMPARE look up the live request; otherwise the latched miss set.
   assign rd_idx   = (state_q == COMPARE) ? addr_idx : req_idx_q;
   assign hit      = req && rd_valid && (rd_tag == addr_tag);
   assign cur_word = rd_data[{addr_word, 5'b0} +: 32];

   dcache_array #(.S_INDEX(S_INDEX), .S_TAG(S_TAG)) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (rd_idx),
      .rd_valid_o (rd_valid),
      .rd_dirty_o (rd_dirty),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (we),
      .wr_idx_i   (rd_idx),
      .wr_valid_i (wr_valid),
      .wr_dirty_i (wr_dirty),
      .wr_tag_i   (wr_tag),
      .wr_data_i  (wr_data)
   );

   // State and latched miss address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         req_tag_q <= '0;
         req_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         req_tag_q <= req_tag_d;
         req_idx_q <= req_idx_d;
      end
   end

   // Next state, handshake outputs and array write-back of the selected set.
   always_comb begin
      state_d      = state_q;
      req_tag_d    = req_tag_q;
      req_idx_d    = req_idx_q;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      we           = 1'b0;
      wr_valid     = rd_valid;
      wr_dirty     = rd_dirty;
      wr_tag       = rd_tag;
      wr_data      = rd_data;
      case (state_q)
         IDLE: begin
            if (req) state_d = COMPARE;
         end
         COMPARE: begin
            if (!req) begin
               state_d = IDLE;
            end else if (hit) begin
               mem_resp = 1'b1;
               state_d  = IDLE;
               if (mem_write) begin
                  // Write wins when both read and write are asserted.
                  we       = 1'b1;
                  wr_dirty = 1'b1;
                  wr_data[{addr_word, 5'b0} +: 32] =
                     be_merge(cur_word, mem_wdata, mem_byte_enable);
               end else begin
                  mem_rdata = cur_word;
               end
            end else begin
               req_tag_d = addr_tag;
               req_idx_d = addr_idx;
               state_d   = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {rd_tag, req_idx_q, {S_OFFSET{1'b0}}};
            pmem_wdata   = rd_data;
            if (pmem_resp) begin
               we       = 1'b1;
               wr_dirty = 1'b0;
               state_d  = req ? ALLOCATE : IDLE;
            end
         end
         ALLOCATE: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag_q, req_idx_q, {S_OFFSET{1'b0}}};
            if (pmem_resp) begin
               we       = 1'b1;
               wr_valid = 1'b1;
               wr_dirty = 1'b0;
               wr_tag   = req_tag_q;
               wr_data  = pmem_rdata;
               state_d  = req ? COMPARE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DCACHE_PERF_COUNTERS_EN
   logic        recmp_q;
   logic [31:0] hits_q, misses_q;

   // Saturating counters; the hit after a fill is not a fresh hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         recmp_q  <= 1'b0;
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         recmp_q <= (state_q == ALLOCATE) && pmem_resp;
         if (state_q == COMPARE && req) begin
            if (hit && !recmp_q && hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
            if (!hit && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
         end
      end
   end

   assign perf_hits   = hits_q;
   assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: vector table of full CPU requests against a
// fixed-latency line memory model, plus hand-written drop/reset sequences.
module tb_l1_dcache;
   localparam int LAT = 2;            // extra cycles before pmem_resp
   localparam int HIT_LAT   = 1;
   localparam int CLEAN_LAT = LAT + 3;
   localparam int DIRTY_LAT = 2*LAT + 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         mem_read = 1'b0, mem_write = 1'b0;
   logic [3:0]   mem_byte_enable = '0;
   logic [31:0]  mem_address = '0, mem_wdata = '0;
   logic         mem_resp;
   logic [31:0]  mem_rdata;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   l1_dcache dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   logic [255:0] mem [logic [31:0]];
   int           n_fill = 0, n_wb = 0;
   logic [31:0]  fill_addr = '0, wb_addr = '0, start_addr = '0;
   int           cnt = 0;

   function automatic logic [31:0] pat(input logic [31:0] la, input int w);
      return {la[23:0], 5'b0, 3'(w)};
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] la);
      logic [255:0] l;
      if (mem.exists(la)) return mem[la];
      for (int w = 0; w < 8; w++) l[32*w +: 32] = pat(la, w);
      return l;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Line memory: answers LAT cycles after a request appears, one-cycle resp.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         pmem_resp = 1'b0;
         if (rst || !(pmem_read || pmem_write)) begin
            cnt = 0;
         end else if (cnt == LAT) begin
            cnt = 0;
            pmem_resp = 1'b1;
            chk("pmem_excl", {31'b0, pmem_read && pmem_write}, 32'd0);
            chk("pmem_addr_stable", pmem_address, start_addr);
            if (pmem_write) begin
               mem[pmem_address] = pmem_wdata;
               n_wb++;
               wb_addr = pmem_address;
            end else begin
               pmem_rdata = line_of(pmem_address);
               n_fill++;
               fill_addr = pmem_address;
            end
         end else begin
            if (cnt == 0) start_addr = pmem_address;
            cnt++;
         end
      end
   end

   task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdata, output int lat, output logic ok);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_byte_enable = be;
      mem_address = a; mem_wdata = wd;
      lat = 0; ok = 1'b0; rdata = '0;
      while (!ok && lat < 100) begin
         @(negedge clk);
         lat++;
         if (mem_resp) begin
            ok = 1'b1;
            rdata = mem_rdata;
         end
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   typedef struct {
      logic        rd, wr;
      logic [3:0]  be;
      logic [31:0] addr, wdata, exp_rdata;
      int          lat, nfill, nwb;
      logic [31:0] fill_a, wb_a;
   } vec_t;

   vec_t v [13];

   initial begin
      logic [255:0] l40;
      logic [31:0]  rdata;
      int           lat, f0, w0, k;
      logic         ok, seen_resp;

      // Line 0x40 has words 0 and 2 = DEADBEEF, rest patterned.
      l40 = line_of(32'h40);
      l40[31:0]  = 32'hDEADBEEF;
      l40[95:64] = 32'hDEADBEEF;
      mem[32'h40] = l40;

      //         rd    wr    be     addr          wdata         exp_rdata     lat        fill wb fill_a        wb_a
      v[0]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0,        32'hDEADBEEF, CLEAN_LAT, 1, 0, 32'h40,       32'h0};
      v[1]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0,        32'hDEADBEEF, HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[2]  = '{1'b0, 1'b1, 4'h5, 32'h0000_0048, 32'h11223344, 32'h0,        HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0,        32'hDE22BE44, HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[4]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0,        32'h00004001, HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0248, 32'h0,        32'h00024002, DIRTY_LAT, 1, 1, 32'h240,      32'h40};
      v[6]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0048, 32'h0,        32'hDE22BE44, CLEAN_LAT, 1, 0, 32'h40,       32'h0};
      v[7]  = '{1'b1, 1'b1, 4'hF, 32'h0000_004C, 32'hCAFEF00D, 32'h0,        HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000_004C, 32'h0,        32'hCAFEF00D, HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[9]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0050, 32'hFFFFFFFF, 32'h0,        HIT_LAT,   0, 0, 32'h0,        32'h0};
      v[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_0250, 32'h0,        32'h00024004, DIRTY_LAT, 1, 1, 32'h240,      32'h40};
      v[11] = '{1'b0, 1'b1, 4'hC, 32'h0000_1004, 32'hAABBCCDD, 32'h0,        CLEAN_LAT, 1, 0, 32'h1000,     32'h0};
      v[12] = '{1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0,        32'hAABB0001, HIT_LAT,   0, 0, 32'h0,        32'h0};

      // Reset state.
      @(negedge clk);
      chk("rst_mem_resp",   {31'b0, mem_resp},   32'd0);
      chk("rst_pmem_read",  {31'b0, pmem_read},  32'd0);
      chk("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
      chk("rst_mem_rdata",  mem_rdata,           32'd0);
      chk("rst_pmem_addr",  pmem_address,        32'd0);
      chk("rst_pmem_wdata", {31'b0, |pmem_wdata}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         f0 = n_fill; w0 = n_wb;
         do_req(v[i].rd, v[i].wr, v[i].be, v[i].addr, v[i].wdata, rdata, lat, ok);
         chk($sformatf("v%0d_resp", i), {31'b0, ok}, 32'd1);
         if (v[i].rd && !v[i].wr) chk($sformatf("v%0d_rdata", i), rdata, v[i].exp_rdata);
         chk($sformatf("v%0d_lat", i),   32'(lat),       32'(v[i].lat));
         chk($sformatf("v%0d_fills", i), 32'(n_fill-f0), 32'(v[i].nfill));
         chk($sformatf("v%0d_wbs", i),   32'(n_wb-w0),   32'(v[i].nwb));
         if (v[i].nfill > 0) chk($sformatf("v%0d_fill_addr", i), fill_addr, v[i].fill_a);
         if (v[i].nwb > 0)   chk($sformatf("v%0d_wb_addr", i),   wb_addr,   v[i].wb_a);
         @(negedge clk);
         chk($sformatf("v%0d_resp_single", i), {31'b0, mem_resp}, 32'd0);
      end

      // Written-back line 0x40 carries the merged word, the R+W write and
      // the untouched word behind a zero byte-enable write.
      l40 = mem[32'h40];
      chk("wb_line_w2", l40[95:64],   32'hDE22BE44);
      chk("wb_line_w3", l40[127:96],  32'hCAFEF00D);
      chk("wb_line_w4", l40[159:128], 32'h00004004);

      // Request dropped during ALLOCATE: fill completes, no mem_resp.
      f0 = n_fill;
      seen_resp = 1'b0;
      @(negedge clk);
      mem_read = 1'b1; mem_address = 32'h0000_00E4;
      k = 0;
      while (!pmem_read && k < 20) begin @(negedge clk); k++; end
      chk("drop_alloc_seen", {31'b0, pmem_read}, 32'd1);
      mem_read = 1'b0;
      k = 0;
      while (n_fill == f0 && k < 20) begin
         @(negedge clk); k++;
         if (mem_resp) seen_resp = 1'b1;
      end
      repeat (3) begin
         @(negedge clk);
         if (mem_resp) seen_resp = 1'b1;
      end
      chk("drop_fill_done", 32'(n_fill-f0), 32'd1);
      chk("drop_no_resp", {31'b0, seen_resp}, 32'd0);
      chk("drop_idle_pmem", {30'b0, pmem_read, pmem_write}, 32'd0);
      do_req(1'b1, 1'b0, 4'h0, 32'h0000_00E4, 32'h0, rdata, lat, ok);
      chk("drop_then_hit_lat", 32'(lat), 32'(HIT_LAT));
      chk("drop_then_hit_data", rdata, 32'h0000E001);

      // Reset during ALLOCATE: pmem_read drops at once, lines invalidated.
      @(negedge clk);
      mem_read = 1'b1; mem_address = 32'h0000_0124;
      k = 0;
      while (!pmem_read && k < 20) begin @(negedge clk); k++; end
      chk("rst_alloc_seen", {31'b0, pmem_read}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_pmem_read", {31'b0, pmem_read}, 32'd0);
      chk("rst_mid_pmem_addr", pmem_address, 32'd0);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      f0 = n_fill;
      do_req(1'b1, 1'b0, 4'h0, 32'h0000_00E4, 32'h0, rdata, lat, ok);
      chk("post_rst_miss_lat", 32'(lat), 32'(CLEAN_LAT));
      chk("post_rst_fills", 32'(n_fill-f0), 32'd1);
      chk("post_rst_data", rdata, 32'h0000E001);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
